// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: alternates a read cycle and a write cycle per word,
// accumulating a 16-bit running checksum of the copied data.
module mem_copy_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  src_addr,
    input  logic [7:0]  dst_addr,
    input  logic [7:0]  len,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_w_en,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  src_q;
    logic [7:0]  dst_q;
    logic [7:0]  len_q;
    logic [7:0]  index_q;
    logic [7:0]  index_next;
    logic [15:0] data_q;
    logic [15:0] checksum_q;

    assign index_next = index_q + 8'd1;
    assign checksum   = checksum_q;

    // Gated by rst so a write can never land in a cycle that is being reset.
    assign mem_w_en = (state_q == WR) && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            src_q      <= 8'd0;
            dst_q      <= 8'd0;
            len_q      <= 8'd0;
            index_q    <= 8'd0;
            data_q     <= 16'd0;
            checksum_q <= 16'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        len_q      <= len;
                        index_q    <= 8'd0;
                        checksum_q <= 16'd0;
                    end
                end
                RD: begin
                    data_q     <= mem_rdata;
                    checksum_q <= checksum_q + mem_rdata;
                end
                WR: begin
                    index_q <= index_next;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_addr  = 8'd0;
        mem_wdata = 16'd0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == 8'd0) ? DONE : RD;
                end
            end
            RD: begin
                busy     = 1'b1;
                mem_addr = src_q + index_q;
                state_d  = WR;
            end
            WR: begin
                busy      = 1'b1;
                mem_addr  = dst_q + index_q;
                mem_wdata = data_q;
                state_d   = (index_next == len_q) ? DONE : RD;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed testbench for mem_copy_engine with a behavioural data memory that
// reads combinationally and commits writes on the falling edge.
module tb_mem_copy_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [7:0]  len;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_w_en;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    logic [15:0] mem [256];

    int n_checks;
    int n_fail;
    int wr_cnt;
    int rd_cnt;
    int wr_log [16];
    int rd_log [16];
    logic busy_seen;
    logic done_seen;
    int done_cyc;
    logic [15:0] exp_sum;

    mem_copy_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_w_en  (mem_w_en),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Memory commit plus a log of every read/write address the engine issues.
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (done) done_seen = 1'b1;
        if (mem_w_en) begin
            mem[mem_addr] = mem_wdata;
            if (wr_cnt < 16) wr_log[wr_cnt] = int'(mem_addr);
            wr_cnt = wr_cnt + 1;
        end else if (busy && rst) begin
            if (rd_cnt < 16) rd_log[rd_cnt] = int'(mem_addr);
            rd_cnt = rd_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearLogs();
        wr_cnt    = 0;
        rd_cnt    = 0;
        busy_seen = 1'b0;
        done_seen = 1'b0;
    endtask

    // Issues one start pulse, then counts cycles until done (cycle 1 is the one after the start edge).
    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                                 input int max_cycles, output int dcyc);
        clearLogs();
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcyc  = -1;
        for (int c = 1; c <= max_cycles; c++) begin
            if (done) begin
                dcyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (dcyc > 0) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        src_addr = 8'd0;
        dst_addr = 8'd0;
        len      = 8'd0;
        clearLogs();
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_wen", 32'(mem_w_en), 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_sum", 32'(checksum), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic two-word copy
        $display("[TB] basic copy len=2");
        mem[0] = 16'd1;
        mem[1] = 16'd2;
        applyStimulus(8'd0, 8'd8, 8'd2, 20, done_cyc);
        checkOutput("basic_done_cyc", 32'(done_cyc), 32'd5);
        checkOutput("basic_mem8", 32'(mem[8]), 32'd1);
        checkOutput("basic_mem9", 32'(mem[9]), 32'd2);
        checkOutput("basic_sum", 32'(checksum), 32'd3);
        checkOutput("basic_wr_cnt", 32'(wr_cnt), 32'd2);
        checkOutput("basic_done_pulse", 32'(done), 32'd0);
        checkOutput("basic_idle_busy", 32'(busy), 32'd0);
        checkOutput("basic_idle_addr", 32'(mem_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("basic_sum_hold", 32'(checksum), 32'd3);

        // Zero-length request
        $display("[TB] zero length");
        applyStimulus(8'd5, 8'd6, 8'd0, 10, done_cyc);
        checkOutput("zero_done_cyc", 32'(done_cyc), 32'd1);
        checkOutput("zero_busy_seen", 32'(busy_seen), 32'd0);
        checkOutput("zero_wr_cnt", 32'(wr_cnt), 32'd0);
        checkOutput("zero_sum", 32'(checksum), 32'd0);

        // Forward overlap replicates the first word
        $display("[TB] forward overlap");
        mem[0] = 16'd7;
        mem[1] = 16'd100;
        mem[2] = 16'd200;
        mem[3] = 16'd300;
        applyStimulus(8'd0, 8'd1, 8'd3, 20, done_cyc);
        checkOutput("ovl_done_cyc", 32'(done_cyc), 32'd7);
        checkOutput("ovl_mem1", 32'(mem[1]), 32'd7);
        checkOutput("ovl_mem2", 32'(mem[2]), 32'd7);
        checkOutput("ovl_mem3", 32'(mem[3]), 32'd7);
        checkOutput("ovl_sum", 32'(checksum), 32'd21);

        // Source address wraps past 255
        $display("[TB] address wrap");
        mem[254] = 16'h1111;
        mem[255] = 16'h2222;
        mem[0]   = 16'h3333;
        applyStimulus(8'd254, 8'd10, 8'd3, 20, done_cyc);
        checkOutput("wrap_rd0", 32'(rd_log[0]), 32'd254);
        checkOutput("wrap_rd1", 32'(rd_log[1]), 32'd255);
        checkOutput("wrap_rd2", 32'(rd_log[2]), 32'd0);
        checkOutput("wrap_wr0", 32'(wr_log[0]), 32'd10);
        checkOutput("wrap_wr1", 32'(wr_log[1]), 32'd11);
        checkOutput("wrap_wr2", 32'(wr_log[2]), 32'd12);
        checkOutput("wrap_mem12", 32'(mem[12]), 32'h3333);
        checkOutput("wrap_sum", 32'(checksum), 32'h6666);

        // Reset during the second write cycle aborts the copy
        $display("[TB] reset abort");
        mem[20] = 16'h0101;
        mem[21] = 16'h0202;
        mem[22] = 16'h0303;
        mem[23] = 16'h0404;
        for (int i = 40; i < 44; i++) mem[i] = 16'hDEAD;
        clearLogs();
        src_addr = 8'd20;
        dst_addr = 8'd40;
        len      = 8'd4;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_wr_state", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("abort_wen_gated", 32'(mem_w_en), 32'd0);
        @(posedge clk); #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_sum", 32'(checksum), 32'd0);
        rst = 1'b1;
        clearLogs();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 32'(done_seen), 32'd0);
        checkOutput("abort_no_access", 32'(wr_cnt + rd_cnt), 32'd0);
        checkOutput("abort_mem40", 32'(mem[40]), 32'h0101);
        checkOutput("abort_mem41", 32'(mem[41]), 32'hDEAD);

        // Reset has priority over a simultaneous start
        $display("[TB] reset with start");
        clearLogs();
        rst      = 1'b0;
        start    = 1'b1;
        len      = 8'd5;
        @(posedge clk); #1;
        checkOutput("rststart_busy", 32'(busy), 32'd0);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("rststart_idle", 32'({busy, done}), 32'd0);
        checkOutput("rststart_wr", 32'(wr_cnt), 32'd0);

        // A second start while busy is ignored
        $display("[TB] start while busy");
        mem[30] = 16'h0010;
        mem[31] = 16'h0020;
        mem[32] = 16'h0030;
        mem[100] = 16'hBEEF;
        clearLogs();
        src_addr = 8'd30;
        dst_addr = 8'd50;
        len      = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        src_addr = 8'd0;
        dst_addr = 8'd100;
        len      = 8'd1;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        done_cyc = -1;
        for (int c = 3; c <= 20; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checkOutput("ign_done_cyc", 32'(done_cyc), 32'd7);
        checkOutput("ign_mem50", 32'(mem[50]), 32'h0010);
        checkOutput("ign_mem52", 32'(mem[52]), 32'h0030);
        checkOutput("ign_mem100", 32'(mem[100]), 32'hBEEF);
        checkOutput("ign_sum", 32'(checksum), 32'h0060);
        checkOutput("ign_wr_cnt", 32'(wr_cnt), 32'd3);

        // Maximum length
        $display("[TB] len=255");
        exp_sum = 16'd0;
        for (int i = 0; i < 255; i++) exp_sum = exp_sum + mem[i];
        applyStimulus(8'd0, 8'd0, 8'd255, 600, done_cyc);
        checkOutput("max_done_cyc", 32'(done_cyc), 32'd511);
        checkOutput("max_wr_cnt", 32'(wr_cnt), 32'd255);
        checkOutput("max_sum", 32'(checksum), 32'(exp_sum));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
